// File: rtl/reg_file_scb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared types and defaults for the reg_file_scb register file.
//            Holds the INIT/RUN state enum and default XLEN/NREGS values.
// Ports    : none (package)
// Options  : none
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int c_XLEN_DEF  = 32;
  localparam int c_NREGS_DEF = 32;

  // INIT: post-reset storage sweep; RUN: file usable.
  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } regfile_state_e;

endpackage
`default_nettype wire

// File: rtl/reg_file_scb_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_scb_if
// Purpose  : Bundles the read ports, the write port, the issue port and the
//            ready flag of reg_file_scb.
// Ports    : i_rd_addr/o_rd_data/o_rd_busy - NRD packed read ports
//            i_wr/i_wr_addr/i_wr_data      - synchronous write port
//            i_issue/i_issue_addr          - mark destination busy
//            o_ready                       - init sweep complete
//            modport master: requester side; modport slave: register file
// Options  : none
// Revision : 1.0 - initial release
// ============================================================================
interface reg_file_scb_if
  import regfile_pkg::*;
#(
  parameter int XLEN  = c_XLEN_DEF,
  parameter int NREGS = c_NREGS_DEF,
  parameter int NRD   = 2
);

  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   i_rd_addr;
  logic [NRD*XLEN-1:0] o_rd_data;
  logic [NRD-1:0]      o_rd_busy;
  logic                i_wr;
  logic [AW-1:0]       i_wr_addr;
  logic [XLEN-1:0]     i_wr_data;
  logic                i_issue;
  logic [AW-1:0]       i_issue_addr;
  logic                o_ready;

  modport master (
    output i_rd_addr, i_wr, i_wr_addr, i_wr_data, i_issue, i_issue_addr,
    input  o_rd_data, o_rd_busy, o_ready
  );

  modport slave (
    input  i_rd_addr, i_wr, i_wr_addr, i_wr_data, i_issue, i_issue_addr,
    output o_rd_data, o_rd_busy, o_ready
  );

endinterface
`default_nettype wire

// File: rtl/reg_file_scb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Purpose  : NREGS-bit busy vector tracking in-flight producers, with NRD
//            combinational busy lookups.
// Ports    : clk          - clock
//            i_clr        - synchronous clear of every busy bit
//            i_set/_addr  - mark a register busy (issue)
//            i_done/_addr - mark a register not busy (writeback)
//            i_rd_addr    - NRD packed lookup addresses
//            o_rd_busy    - NRD busy bits
// Options  : none
// Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREGS = c_NREGS_DEF,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  wire logic              clk,
  input  wire logic              i_clr,
  input  wire logic              i_set,
  input  wire logic [AW-1:0]     i_set_addr,
  input  wire logic              i_done,
  input  wire logic [AW-1:0]     i_done_addr,
  input  wire logic [NRD*AW-1:0] i_rd_addr,
  output logic      [NRD-1:0]    o_rd_busy
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_set_vec;
  logic [NREGS-1:0] w_done_vec;
  logic [NREGS-1:0] w_busy_nxt;

  // The set term is OR-ed in after the clear so that an issue and a
  // writeback to the same register leave it busy (the new producer wins).
  always_comb begin
    w_set_vec  = '0;
    w_done_vec = '0;
    if (i_set)  w_set_vec[i_set_addr]   = 1'b1;
    if (i_done) w_done_vec[i_done_addr] = 1'b1;
    w_busy_nxt    = (r_busy & ~w_done_vec) | w_set_vec;
    w_busy_nxt[0] = 1'b0;  // x0 is never busy
  end

  always_ff @(posedge clk) begin
    if (i_clr) r_busy <= '0;
    else       r_busy <= w_busy_nxt;
  end

  always_comb begin
    o_rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      o_rd_busy[k] = r_busy[i_rd_addr[k*AW +: AW]];
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_file_scb.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_scb
// Purpose  : Integer register file with NRD combinational read ports, one
//            synchronous write port and a busy scoreboard. After reset a
//            sweep zeroes x1..x(NREGS-1), one entry per clock, so storage
//            needs no per-bit reset. x0 always reads 0 and is never busy.
// Ports    : clk   - clock
//            rst_n - synchronous active-low reset
//            bus   - reg_file_scb_if.slave (read/write/issue/ready)
// Options  : REGFILE_BYPASS_EN - write-first bypass from the write port to
//            the read ports in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_scb
  import regfile_pkg::*;
#(
  parameter  int XLEN  = c_XLEN_DEF,
  parameter  int NREGS = c_NREGS_DEF,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  reg_file_scb_if.slave  bus
);

  regfile_state_e  r_state;
  regfile_state_e  w_state_nxt;
  logic [AW-1:0]   r_cnt;
  logic [AW-1:0]   w_cnt_nxt;
  logic            w_run;
  logic            w_mem_we;
  logic [AW-1:0]   w_mem_addr;
  logic [XLEN-1:0] w_mem_data;
  logic            w_wr_ok;
  logic            w_issue_ok;
  logic [NRD-1:0]  w_sb_busy;
  logic [NRD*XLEN-1:0] w_rd_data;
  logic [NRD-1:0]      w_rd_busy;

  logic [XLEN-1:0] r_mem [NREGS];

  assign w_run      = (r_state == RUN);
  assign w_wr_ok    = w_run && rst_n && bus.i_wr && (bus.i_wr_addr != '0);
  assign w_issue_ok = w_run && rst_n && bus.i_issue && (bus.i_issue_addr != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= INIT;
      r_cnt   <= AW'(1);
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The storage write port is shared between the sweep and normal writes.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mem_we    = 1'b0;
    w_mem_addr  = bus.i_wr_addr;
    w_mem_data  = bus.i_wr_data;
    case (r_state)
      INIT: begin
        w_mem_we   = rst_n;
        w_mem_addr = r_cnt;
        w_mem_data = '0;
        w_cnt_nxt  = r_cnt + AW'(1);
        if (r_cnt == AW'(NREGS - 1)) w_state_nxt = RUN;
      end
      RUN: begin
        w_mem_we = w_wr_ok;
      end
      default: w_state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_data;
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD)
  ) u_scoreboard (
    .clk         (clk),
    .i_clr       (!rst_n),
    .i_set       (w_issue_ok),
    .i_set_addr  (bus.i_issue_addr),
    .i_done      (w_wr_ok),
    .i_done_addr (bus.i_wr_addr),
    .i_rd_addr   (bus.i_rd_addr),
    .o_rd_busy   (w_sb_busy)
  );

  // Reads are zero during the sweep and for x0; storage is only trusted in RUN.
  always_comb begin
    w_rd_data = '0;
    w_rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      if (w_run && (bus.i_rd_addr[k*AW +: AW] != '0)) begin
        w_rd_data[k*XLEN +: XLEN] = r_mem[bus.i_rd_addr[k*AW +: AW]];
        w_rd_busy[k]              = w_sb_busy[k];
`ifdef REGFILE_BYPASS_EN
        if (bus.i_wr && (bus.i_wr_addr == bus.i_rd_addr[k*AW +: AW])) begin
          w_rd_data[k*XLEN +: XLEN] = bus.i_wr_data;
          w_rd_busy[k]              = 1'b0;
        end
`endif
      end
    end
  end

  assign bus.o_rd_data = w_rd_data;
  assign bus.o_rd_busy = w_rd_busy;
  assign bus.o_ready   = w_run;

endmodule
`default_nettype wire

// File: doc/reg_file_scb.md
# reg_file_scb

Parametrised integer register file for the decode/writeback boundary of the core: NRD combinational read ports, one synchronous write port, and a per-register busy scoreboard that tracks in-flight producers. After reset, a sweep clears the storage one entry per cycle, so the array maps onto LUTRAM without a per-bit reset. Register 0 is hardwired to zero and never busy.

## Interface
Parameters:
- XLEN, 32, data width
- NREGS, 32, register count; power of two, ≥ 4
- NRD, 2, number of read ports; 1..4
- AW = $clog2(NREGS), derived, not overridable

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- i_rd_addr  in  NRD*AW  read addresses; port k is bits [k*AW +: AW]
- o_rd_data  out  NRD*XLEN  read data; port k is bits [k*XLEN +: XLEN]
- o_rd_busy  out  NRD  port k's register has an outstanding producer
- i_wr  in  1  write enable
- i_wr_addr  in  AW  write address
- i_wr_data  in  XLEN  write data
- i_issue  in  1  mark destination as busy (instruction issued)
- i_issue_addr  in  AW  destination being issued
- o_ready  out  1  init sweep complete; file usable

## Operation
- States: INIT, RUN. rst_n=0 forces INIT, sweep counter=1, all busy bits cleared.
- INIT: each clock with rst_n=1 writes 0 to reg[counter], then counter++. When counter==NREGS-1 is written, go to RUN. i_wr and i_issue are ignored. All o_rd_data=0, o_rd_busy=0, o_ready=0.
- RUN: o_ready=1. The state is terminal until rst_n=0.
- Write: i_wr && i_wr_addr!=0 updates reg[i_wr_addr] at the edge and clears busy[i_wr_addr].
- Issue: i_issue && i_issue_addr!=0 sets busy[i_issue_addr] at the edge. Issue to an already-busy register leaves it busy.
- Issue and write to the same address in the same cycle: set wins, so the register ends busy (new producer).
- Read port k: address 0 gives data 0 and busy 0. Otherwise it returns reg[addr] and busy[addr], both combinational.
- Write to address 0 or issue to address 0: no effect.

## Timing
- Reset values: o_ready=0, o_rd_data=0, o_rd_busy=0. Storage is undefined until the sweep completes.
- Sweep: o_ready rises after exactly NREGS-1 clock edges with rst_n=1 (31 for the default).
- Read latency: 0 cycles (combinational from i_rd_addr and state).
- Write visibility: a write is visible on reads in the cycle after its edge. With bypass enabled it is also visible in the same cycle (see Configuration).
- Busy update: visible in the cycle after the issue or write edge.
- Reset asserted mid-sweep or in RUN: INIT is entered at the next edge, busy is cleared, and the sweep restarts at reg 1.

## Configuration
- REGFILE_BYPASS_EN defined: on read port k, if i_wr && i_wr_addr==addr_k && addr_k!=0 in RUN, then o_rd_data=i_wr_data and o_rd_busy=0 in the same cycle (write-first).
- Undefined: reads return the stored value and the registered busy bit; the new value appears the next cycle.

## Structure
- Package regfile_pkg holds the state enum (INIT, RUN) and the default XLEN/NREGS constants.
- Sub-module regfile_scoreboard holds the NREGS-bit busy vector with its set/clear/priority logic, NRD busy lookups, and a synchronous clear input.
- The top level holds the storage array, the sweep counter/FSM, the read muxes and the bypass.

## Test plan
- Reset release: hold rst_n=0 for 3 cycles, then release. o_ready=0 for 31 cycles and 1 from the 32nd. All reads of x1..x31 return 0.
- Write/read: write x5=0xDEADBEEF. Port0 reads x5 next cycle as 0xDEADBEEF. Write x0=0x1234, then read x0 → 0 on every port.
- Scoreboard: issue x7, then o_rd_busy for x7 is 1 next cycle. Write x7=0x55, then busy is 0 next cycle. Issue and write x7 in the same cycle → busy stays 1.
- Bypass: with REGFILE_BYPASS_EN, write x9=0xA5A5A5A5 while port1 reads x9 → same-cycle data 0xA5A5A5A5, busy 0. Without the macro, the old value is returned in that cycle.
- Ignored during INIT: i_wr to x3=0xFF and i_issue x3 during the sweep, then after o_ready, x3=0 and busy 0.
- Reset in RUN: with x5 busy, assert rst_n for 1 cycle. o_ready drops and busy clears. After 31 cycles, x5 reads 0.
